// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined), LSB first, baud picked by brate_selection.
// Ports: clk, rst (async, active high), brate_selection (00=9600 01=19200
//        10=57600 11=115200), tx_data/tx_valid/tx_ready push side,
//        tx_out serial line (idle high), busy, fifo_count (bytes queued).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         brate_selection,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_out,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int BW = $clog2(CLK_FREQ / 9600 + 1);
  localparam logic [BW-1:0] DIV0 = BW'(CLK_FREQ / 9600);
  localparam logic [BW-1:0] DIV1 = BW'(CLK_FREQ / 19200);
  localparam logic [BW-1:0] DIV2 = BW'(CLK_FREQ / 57600);
  localparam logic [BW-1:0] DIV3 = BW'(CLK_FREQ / 115200);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t r_state, w_state_d;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;

  logic [BW-1:0] r_bcnt, w_bcnt_d;
  logic [BW-1:0] r_div, w_div_d;
  logic [BW-1:0] w_sel_div;
  logic [2:0]    r_bidx, w_bidx_d;
  logic [7:0]    r_shreg, w_shreg_d;
  logic          r_tx, w_tx_d;
`ifdef UART_TX_PARITY_EN
  logic          r_par, w_par_d;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_nempty;
  logic       w_bend;
  logic [7:0] w_head;

  assign w_nempty   = (r_count != '0);
  assign tx_ready   = (r_count != FULL);
  assign w_push     = tx_valid && tx_ready;
  assign w_head     = r_mem[r_rptr];
  assign w_bend     = (r_bcnt == r_div - BW'(1));
  assign tx_out     = r_tx;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || w_nempty;

  always_comb begin
    w_sel_div = DIV0;
    case (brate_selection)
      2'b00:   w_sel_div = DIV0;
      2'b01:   w_sel_div = DIV1;
      2'b10:   w_sel_div = DIV2;
      default: w_sel_div = DIV3;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_bcnt_d  = r_bcnt + BW'(1);
    w_div_d   = r_div;
    w_bidx_d  = r_bidx;
    w_shreg_d = r_shreg;
`ifdef UART_TX_PARITY_EN
    w_par_d   = r_par;
`endif
    w_pop     = 1'b0;
    w_tx_d    = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_bcnt_d = '0;
        w_pop    = w_nempty;
      end
      S_START: begin
        if (w_bend) begin
          w_bcnt_d  = '0;
          w_bidx_d  = '0;
          w_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bend) begin
          w_bcnt_d  = '0;
          w_shreg_d = {1'b0, r_shreg[7:1]};
          w_bidx_d  = r_bidx + 3'd1;
          if (r_bidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = S_PARITY;
`else
            w_state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bend) begin
          w_bcnt_d  = '0;
          w_state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bend) begin
          w_bcnt_d  = '0;
          w_state_d = S_IDLE;
          w_pop     = w_nempty;
        end
      end
      default: begin
        w_bcnt_d  = '0;
        w_state_d = S_IDLE;
      end
    endcase

    // A pop always starts a new frame; the rate is frozen here.
    if (w_pop) begin
      w_state_d = S_START;
      w_bcnt_d  = '0;
      w_div_d   = w_sel_div;
      w_shreg_d = w_head;
`ifdef UART_TX_PARITY_EN
      w_par_d   = ^w_head;
`endif
    end

    // Line level is taken from the next state so tx_out is a flop.
    case (w_state_d)
      S_START: w_tx_d = 1'b0;
      S_DATA:  w_tx_d = w_shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_d = w_par_d;
`endif
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_div   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_bcnt  <= w_bcnt_d;
      r_div   <= w_div_d;
      r_bidx  <= w_bidx_d;
      r_shreg <= w_shreg_d;
      r_tx    <= w_tx_d;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo; a serial-line monitor
// checks every frame against a queue of expected bytes and bit periods.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 10_000_000;
  localparam int D00 = 1041;
  localparam int D11 = 86;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * D11;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .FIFO_DEPTH(16),
    .FIFO_AW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .brate_selection(sel),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out(tx_out),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t expq[$];
  int   starts[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [7:0] d, input int v);
    expq.push_back('{data: d, div: v});
  endtask

  task automatic stop_now(input string nm);
    errors++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench stopped");
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_start(input int n, input int bound, input string nm);
    int k = 0;
    while (starts.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (starts.size() < n) stop_now(nm);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int k = 0;
    while ((busy !== 1'b0 || expq.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= bound) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles", nm, bound);
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: each cycle of each bit must sit at the expected level.
  task automatic run_frame();
    exp_t        e;
    logic [10:0] bits;
    int          good;
    starts.push_back(cyc);
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: start at cycle %0d, want none", cyc);
      for (int k = 0; k < 20000 && busy !== 1'b0; k++) @(negedge clk);
      return;
    end
    e = expq.pop_front();
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^e.data;
`endif
    for (int b = 0; b < NB; b++) begin
      good = 0;
      for (int c = 0; c < e.div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (rst) return;
        if (tx_out === bits[b]) good++;
      end
      checks++;
      if (good != e.div) begin
        errors++;
        $display("FAIL frame_%02h_bit%0d: %0d of %0d cycles at level %0d",
                 e.data, b, good, e.div, bits[b]);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && tx_out === 1'b0) run_frame();
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    stop_now("watchdog");
  end

  initial begin : stim
    int t;
    int s;
    int n0;
    int n1;
    rst = 1'b1;
    sel = 2'b11;
    tx_data = '0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // single byte: latency, frame timing, busy fall
    n0 = starts.size();
    @(negedge clk);
    t = cyc;
    exp_push(8'hA5, D11);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start(n0 + 1, 10, "t1_start");
    s = starts[n0];
    chk("t1_latency", s - t, 2);
    wait_cyc(s + FL - 1);
    chk("t1_busy_in_stop", busy, 1);
    wait_cyc(s + FL);
    chk("t1_busy_after", busy, 0);
    chk("t1_idle_line", tx_out, 1);
    wait_idle(20, "t1_idle");

    // back-to-back frames
    n0 = starts.size();
    @(negedge clk);
    exp_push(8'h00, D11);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("t2_count_a", fifo_count, 1);
    exp_push(8'hFF, D11);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t2_count_b", fifo_count, 1);
    wait_start(n0 + 2, FL + 20, "t2_start");
    chk("t2_gap", starts[n0+1] - starts[n0], FL);
    chk("t2_count_c", fifo_count, 0);
    wait_idle(FL + 20, "t2_idle");

    // FIFO full: 0 popped at once, 1..16 queued, 17..19 dropped
    for (int i = 0; i <= 16; i++) exp_push(8'(i), D11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_data = 8'(i);
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t3_count_full", fifo_count, 16);
    chk("t3_ready_low", tx_ready, 0);
    wait_idle(17 * FL + 100, "t3_idle");

    // rate change mid-frame only affects the next frame
    sel = 2'b00;
    n0 = starts.size();
    @(negedge clk);
    exp_push(8'h3C, D00);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    exp_push(8'hC3, D11);
    tx_data = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start(n0 + 1, 10, "t4_start");
    s = starts[n0];
    wait_cyc(s + 3 * D00);
    sel = 2'b11;
    wait_start(n0 + 2, NB * D00 + 20, "t4_start2");
    chk("t4_gap", starts[n0+1] - starts[n0], NB * D00);
    wait_idle(FL + 20, "t4_idle");

    // reset during data bit 3 with 4 bytes still queued
    n0 = starts.size();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_push(8'(i * 17), D11);
      tx_data = 8'(i * 17);
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start(n0 + 1, 10, "t5_start");
    s = starts[n0];
    wait_cyc(s + 4 * D11 + D11 / 2);
    chk("t5_count_before", fifo_count, 4);
    #2 rst = 1'b1;
    #1;
    chk("t5_tx_out_async", tx_out, 1);
    chk("t5_count_async", fifo_count, 0);
    chk("t5_busy_async", busy, 0);
    expq.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    n1 = starts.size();
    wait_cyc(cyc + 3 * FL);
    chk("t5_no_frames", starts.size(), n1);
    chk("t5_line_idle", tx_out, 1);
    chk("t5_count_after", fifo_count, 0);

    // 8'h07: parity bit 1 when enabled, frame NB bit periods long
    n0 = starts.size();
    @(negedge clk);
    exp_push(8'h07, D11);
    tx_data = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start(n0 + 1, 10, "t6_start");
    s = starts[n0];
    wait_cyc(s + FL - 1);
    chk("t6_busy_in_stop", busy, 1);
    wait_cyc(s + FL);
    chk("t6_busy_after", busy, 0);
    wait_idle(20, "t6_idle");

    chk("expq_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
